// File: rtl/pc_control_fsm.sv
// Multi-cycle sequencer: fetch/decode/execute/update of 16-bit instructions.
// Owns the flag register and issues one PC strobe per instruction.
module pc_control_fsm #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_instr,
  input  logic             i_instrValid,
  input  logic [4:0]       i_aluFlags,
  input  logic [WIDTH-1:0] i_regTarget,
  output logic             o_fetchReq,
  output logic             o_pcAdd,
  output logic             o_pcBranch,
  output logic             o_pcJump,
  output logic [3:0]       o_flagOp,
  output logic [WIDTH-1:0] o_immediate,
  output logic [WIDTH-1:0] o_flagRegister,
  output logic             o_regWrite,
  output logic             o_flagWrite,
  output logic [3:0]       o_aluOp,
  output logic [3:0]       o_regDst,
  output logic [3:0]       o_regSrc,
  output logic             o_useImm
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_UPDATE
  } state_t;

  typedef enum logic [1:0] {
    C_NOP,
    C_ALU,
    C_BR,
    C_JMP
  } cls_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_ir;
  logic [3:0]       r_flagOp;
  logic [WIDTH-1:0] r_imm;
  logic [4:0]       r_flags;
  logic             r_taken;

  cls_t       w_cls;
  logic [3:0] w_op;
  logic [3:0] w_cond;
  logic [3:0] w_aluOp;
  logic       w_useImm;
  logic       w_isImm;
  logic       w_taken;
  logic       w_flagWr;
  logic       w_regWr;
  logic       w_br;
  logic       w_jmp;

  assign w_op   = r_ir[15:12];
  assign w_cond = r_ir[11:8];

  assign w_isImm = (w_op == 4'h1) || (w_op == 4'h2) ||
                   (w_op == 4'h3) || (w_op == 4'h5) ||
                   (w_op == 4'h9) || (w_op == 4'hB) ||
                   (w_op == 4'hD);

  always_comb begin
    w_cls    = C_NOP;
    w_aluOp  = 4'h0;
    w_useImm = 1'b0;
    unique case (1'b1)
      (w_op == 4'h0): begin
        w_cls   = C_ALU;
        w_aluOp = r_ir[7:4];
      end
      w_isImm: begin
        w_cls    = C_ALU;
        w_aluOp  = w_op;
        w_useImm = 1'b1;
      end
      (w_op == 4'hC): w_cls = C_BR;
      (w_op == 4'h4 && r_ir[7:4] == 4'hC): w_cls = C_JMP;
      default: w_cls = C_NOP;
    endcase
  end

  // flag bits: C=0, L=1, F=2, Z=3, N=4
  always_comb begin
    w_taken = 1'b0;
    case (w_cond)
      4'h0: w_taken = r_flags[3];
      4'h1: w_taken = !r_flags[3];
      4'h2: w_taken = r_flags[0];
      4'h3: w_taken = !r_flags[0];
      4'h4: w_taken = r_flags[1];
      4'h5: w_taken = !r_flags[1];
      4'h6: w_taken = r_flags[4];
      4'h7: w_taken = !r_flags[4];
      4'h8: w_taken = r_flags[2];
      4'h9: w_taken = !r_flags[2];
      4'hA: w_taken = !r_flags[1] && !r_flags[3];
      4'hB: w_taken = r_flags[1] || r_flags[3];
      4'hC: w_taken = !r_flags[4] && !r_flags[3];
      4'hD: w_taken = r_flags[4] || r_flags[3];
      4'hE: w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    w_next = S_FETCH;
      S_FETCH:   if (i_instrValid) w_next = S_DECODE;
      S_DECODE:  w_next = S_EXECUTE;
      S_EXECUTE: w_next = S_UPDATE;
      S_UPDATE:  w_next = S_FETCH;
      default:   w_next = S_IDLE;
    endcase
  end

  assign w_regWr  = (r_state == S_EXECUTE) && (w_cls == C_ALU) &&
                    (w_aluOp != 4'hB);
  assign w_flagWr = (r_state == S_EXECUTE) && (w_cls == C_ALU) &&
                    ((w_aluOp == 4'h5) || (w_aluOp == 4'h9) ||
                     (w_aluOp == 4'hB));
  assign w_br     = (r_state == S_UPDATE) && (w_cls == C_BR) && r_taken;
  assign w_jmp    = (r_state == S_UPDATE) && (w_cls == C_JMP) && r_taken;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_ir     <= '0;
      r_flagOp <= '0;
      r_imm    <= '0;
      r_flags  <= '0;
      r_taken  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && i_instrValid) r_ir <= i_instr;
      if (r_state == S_DECODE) begin
        if (w_cls == C_BR) begin
          r_flagOp <= w_cond;
          r_imm    <= {{(WIDTH-8){r_ir[7]}}, r_ir[7:0]};
        end else if (w_cls == C_JMP) begin
          r_flagOp <= w_cond;
          r_imm    <= i_regTarget;
        end
      end
      if (r_state == S_EXECUTE) begin
        r_taken <= w_taken;
        if (w_flagWr) r_flags <= i_aluFlags;
      end
    end
  end

  assign o_fetchReq     = (r_state == S_FETCH);
  assign o_pcBranch     = w_br;
  assign o_pcJump       = w_jmp;
  assign o_pcAdd        = (r_state == S_UPDATE) && !w_br && !w_jmp;
  assign o_regWrite     = w_regWr;
  assign o_flagWrite    = w_flagWr;
  assign o_flagOp       = r_flagOp;
  assign o_immediate    = r_imm;
  assign o_flagRegister = {{(WIDTH-5){1'b0}}, r_flags};
  assign o_aluOp        = w_aluOp;
  assign o_useImm       = w_useImm;
  assign o_regDst       = r_ir[11:8];
  assign o_regSrc       = r_ir[3:0];

endmodule

// File: doc/pc_control_fsm.md
# pc_control_fsm

Multi-cycle instruction sequencer that drives the program counter's control inputs. It fetches a 16-bit instruction, decodes ALU, Bcond and Jcond forms, and owns the architectural flag register. It evaluates branch conditions itself and issues exactly one PC strobe per instruction: `pcAdd`, `pcBranch` or `pcJump`. The PC only moves on a taken condition, so every not-taken branch or jump must arrive as `pcAdd`.

## Interface
- `WIDTH`, 16, instruction, immediate and flag-register width.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `instr`  in  16  instruction word from memory.
- `instrValid`  in  1  `instr` valid; sampled only in FETCH.
- `aluFlags`  in  5  ALU result flags {N,Z,F,L,C} as bits [4:0].
- `regTarget`  in  16  register-file read data for the Jcond target register.
- `fetchReq`  out  1  instruction read request.
- `pcAdd`, `pcBranch`, `pcJump`  out  1 each  one-cycle PC strobes, mutually exclusive.
- `flagOp`  out  4  condition code sent to the PC.
- `immediate`  out  16  sign-extended branch displacement or absolute jump target.
- `flagRegister`  out  16  bits C=0, L=1, F=2, Z=3, N=4; bits [15:5] always 0.
- `regWrite`, `flagWrite`  out  1 each  register-file and flag write enables.
- `aluOp`  out  4  ALU operation code.
- `regDst`, `regSrc`  out  4 each  register addresses (`instr[11:8]`, `instr[3:0]`).
- `useImm`  out  1  ALU B operand is sign-extended `instr[7:0]`.

## Operation
- States: IDLE → FETCH → DECODE → EXECUTE → UPDATE → FETCH.
- IDLE is entered only from reset and lasts 1 cycle.
- FETCH:
  - `fetchReq`=1.
  - Stays in FETCH until `instrValid`=1.
  - On that edge, `instr` is latched into the internal IR and the FSM moves to DECODE.
- DECODE (1 cycle): the class is decided from IR.
  - ALU-register: `op[15:12]`=0000, `aluOp`=`IR[7:4]`.
  - ALU-immediate: `op` ∈ {0001,0010,0011,0101,1001,1011,1101}, `aluOp`=`op`, `useImm`=1.
  - Bcond: `op`=1100, cond=`IR[11:8]`, disp=`IR[7:0]`.
  - Jcond: `op`=0100 and `IR[7:4]`=1100, cond=`IR[11:8]`, target register=`IR[3:0]` (driven on `regSrc`).
  - Anything else: NOP.
- EXECUTE (1 cycle):
  - ALU: `regWrite`=1 unless the code is CMP (1011).
  - ALU, codes ADD 0101, SUB 1001, CMP 1011 only: `flagWrite`=1 and `flagRegister[4:0]` ← `aluFlags` at the end of the cycle.
  - Bcond: taken computed from the current `flagRegister`; `immediate` ← sign-extend(disp).
  - Jcond: taken computed from the current `flagRegister`; `immediate` ← `regTarget`.
- Condition codes (taken when):
  - EQ 0000: Z. NE 0001: !Z.
  - CS 0010: C. CC 0011: !C.
  - HI 0100: L. LS 0101: !L.
  - GT 0110: N. LE 0111: !N.
  - FS 1000: F. FC 1001: !F.
  - LO 1010: !L&&!Z. HS 1011: L||Z.
  - LT 1100: !N&&!Z. GE 1101: N||Z.
  - UC 1110: always.
  - 1111: never.
- UPDATE (1 cycle):
  - Taken Bcond: `pcBranch`=1.
  - Taken Jcond: `pcJump`=1.
  - Otherwise (not-taken, cond 1111, ALU, NOP): `pcAdd`=1.
  - `flagOp` and `immediate` hold their EXECUTE values through UPDATE.
- Reset values:
  - State IDLE; IR 0.
  - `flagRegister`, `immediate`, `flagOp`, `aluOp`, `regDst`, `regSrc` all 0.
  - All strobes and enables 0.

## Timing
- Minimum 4 cycles per instruction (FETCH with `instrValid` already high, DECODE, EXECUTE, UPDATE); each extra wait cycle in FETCH adds 1.
- Strobes, `regWrite` and `flagWrite` are registered state decodes, exactly 1 cycle wide, never back-to-back.
- A flag write from instruction k is visible in `flagRegister` from instruction k's UPDATE cycle, so a branch at k+1 sees it.
- `instrValid` outside FETCH is ignored.
- Reset in any state:
  - Next edge goes to IDLE.
  - No strobe or write enable in the cycle after reset is sampled.
  - Any partially executed instruction is dropped, including an in-flight flag update.
- `immediate` sign extension: `{8{IR[7]}, IR[7:0]}`; disp 0x80 → 0xFF80.

## Test plan
- Reset, then hold `instrValid`=1 with `instr`=0x0000 (ALU, `aluOp` 0): `fetchReq` high in cycle 2; `pcAdd` pulses every 4 cycles; `regWrite` pulses once per instruction.
- CMP immediate 0xB105 with `aluFlags`=5'b01000: `flagRegister` becomes 0x0008 at UPDATE; `regWrite` stays 0; then BEQ 0xC0FE gives `pcBranch`=1, `flagOp`=0, `immediate`=0xFFFE.
- BNE 0xC103 with Z=1: `pcAdd`=1, `pcBranch`=0; UC branch 0xCE10 gives `pcBranch`, `immediate`=0x0010; cond 1111 gives `pcAdd`.
- JUC 0x4EC7 with `regTarget`=0x1234: `pcJump`=1, `flagOp`=0xE, `immediate`=0x1234; JHS with L=0, Z=0 gives `pcAdd`.
- `instrValid` held low 5 cycles in FETCH: FSM stays in FETCH, no strobes; valid pulses during DECODE are ignored.
- `reset` asserted in EXECUTE of ADD: no `flagWrite` or `pcAdd`, `flagRegister`=0, IDLE next cycle, FETCH the cycle after.
